// File: rtl/pll_reconfig_seq_if.sv
// rtl/pll_reconfig_seq_if.sv - Avalon-MM write port between sequencer and PLL reconfig core
interface pll_reconfig_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    output mgmt_read,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    input  mgmt_read,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - PLL retune sequencer: profile writes, trigger, settle, lock wait, timeout
module pll_reconfig_seq #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES  = 64,
  parameter int LOCK_STABLE    = 256
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         freq_sel,
  input  logic               pll_locked,
  pll_reconfig_seq_if.master mgmt,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         cur_sel
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_START, SETTLE, LOCKWAIT, DONE, ERR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  sel_q;
  logic [1:0]  locked_ff;
  logic        locked_sync;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] settle_q;
  logic [LW-1:0] stable_q;
  logic        wr_done;
  logic        timeout;
  logic [31:0] c0_word;

  assign locked_sync = locked_ff[1];
  assign wr_done     = !mgmt.mgmt_waitrequest;
  assign timeout     = (state != IDLE) && (state != ERR) && (state != DONE) &&
                       (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // VCO is 400 MHz; C0 splits the divide evenly into hi/lo halves
  always_comb begin
    case (sel_q)
      2'd0:    c0_word = 32'h0000_0202;
      2'd1:    c0_word = 32'h0000_0404;
      2'd2:    c0_word = 32'h0000_0808;
      default: c0_word = 32'h0000_0101;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 2'd0;
      cur_sel   <= 2'd0;
      error     <= 1'b0;
      timer_q   <= '0;
      settle_q  <= '0;
      stable_q  <= '0;
      locked_ff <= 2'b00;
    end else begin
      state     <= state_next;
      locked_ff <= {locked_ff[0], pll_locked};
      timer_q   <= (state == IDLE) ? '0 : timer_q + TW'(1);
      settle_q  <= (state == SETTLE) ? settle_q + SW'(1) : '0;
      stable_q  <= (state == LOCKWAIT && locked_sync) ? stable_q + LW'(1) : '0;
      if (state == IDLE && start) begin
        sel_q <= freq_sel;
        error <= 1'b0;
      end
      if (state != ERR && state_next == ERR) error <= 1'b1;
      if (state != DONE && state_next == DONE) cur_sel <= sel_q;
    end
  end

  always_comb begin
    state_next          = state;
    mgmt.mgmt_address   = 6'h00;
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_writedata = 32'h0;
    mgmt.mgmt_read      = 1'b0;
    busy                = (state != IDLE) && (state != ERR);
    done                = (state == DONE);

    case (state)
      IDLE:     if (start) state_next = WR_MODE;
      WR_MODE: begin
        mgmt.mgmt_write = 1'b1;
        if (wr_done) state_next = WR_N;
      end
      WR_N: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h03;
        mgmt.mgmt_writedata = 32'h0001_0000;
        if (wr_done) state_next = WR_M;
      end
      WR_M: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h04;
        mgmt.mgmt_writedata = 32'h0000_0404;
        if (wr_done) state_next = WR_C0;
      end
      WR_C0: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h05;
        mgmt.mgmt_writedata = c0_word;
        if (wr_done) state_next = WR_START;
      end
      WR_START: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h02;
        mgmt.mgmt_writedata = 32'h0000_0001;
        if (wr_done) state_next = SETTLE;
      end
      SETTLE:   if (settle_q == SW'(SETTLE_CYCLES - 1)) state_next = LOCKWAIT;
      LOCKWAIT: if (locked_sync && stable_q == LW'(LOCK_STABLE - 1)) state_next = DONE;
      DONE:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Timeout wins over any progress made in the same cycle
    if (timeout) state_next = ERR;
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - Self-checking bench for pll_reconfig_seq
module tb_pll_reconfig_seq;
  localparam int TMO = 2000;
  localparam int SET = 64;
  localparam int LCK = 256;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] freq_sel = 2'd0;
  logic       pll_locked = 1'b1;
  logic       busy, done, error;
  logic [1:0] cur_sel;

  pll_reconfig_seq_if mgmt();

  pll_reconfig_seq #(.TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(SET), .LOCK_STABLE(LCK)) dut (
    .refclk(refclk), .rst(rst), .start(start), .freq_sel(freq_sel), .pll_locked(pll_locked),
    .mgmt(mgmt), .busy(busy), .done(done), .error(error), .cur_sel(cur_sel)
  );

  always #10 refclk = ~refclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          stall_sched[6];
  int          stall_left = 0;
  int          widx = 5;
  logic [5:0]  exp_addr[5];
  logic [31:0] exp_data[5];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          glitch_cyc = -100;
  logic        lock_level = 1'b1;

  typedef struct {
    logic [1:0] sel;
    int         stall_m;
    int         glitch_rel;
    logic       lock;
    int         exp_lat;
    logic       exp_err;
    logic [1:0] exp_cur;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] c0_word(input int sel);
    int mhz[4];
    int div;
    mhz = '{100, 50, 25, 200};
    div = 400 / mhz[sel];
    return 32'(((div / 2) << 8) | (div - div / 2));
  endfunction

  function automatic void load_expect(input int sel);
    exp_addr = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h02};
    exp_data = '{32'h0, 32'h0001_0000, 32'h0000_0404, c0_word(sel), 32'h1};
  endfunction

  function automatic int model_latency(input int stall_sum, input int glitch_rel);
    int lw;
    int gs;
    lw = 5 + stall_sum + 1 + SET;
    if (glitch_rel >= 0) begin
      gs = glitch_rel + 2;
      if (gs >= lw && gs < lw + LCK) return gs + 1 + LCK;
    end
    return lw + LCK;
  endfunction

  // Avalon slave with scheduled stalls, lock driver and done recorder
  initial begin
    mgmt.mgmt_waitrequest = 1'b0;
    forever begin
      @(posedge refclk);
      cyc++;
      #1;
      pll_locked = (cyc == glitch_cyc) ? 1'b0 : lock_level;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mgmt.mgmt_write) begin
        if (widx >= 5) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got addr 0x%0h after 5 writes", mgmt.mgmt_address);
          mgmt.mgmt_waitrequest = 1'b0;
        end else begin
          chk("wr_addr", 64'(mgmt.mgmt_address), 64'(exp_addr[widx]));
          chk("wr_data", 64'(mgmt.mgmt_writedata), 64'(exp_data[widx]));
          if (stall_left > 0) begin
            mgmt.mgmt_waitrequest = 1'b1;
            stall_left--;
          end else begin
            mgmt.mgmt_waitrequest = 1'b0;
            widx++;
            stall_left = stall_sched[widx];
          end
        end
      end else begin
        mgmt.mgmt_waitrequest = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge refclk);
    #2;
  endtask

  task automatic run_seq(input string tag, input logic [1:0] sel, input int glitch_rel, input logic lock,
                         input int poke_rel, input int exp_lat, input logic exp_err, input logic [1:0] exp_cur);
    int acc;
    int end_c;
    bit ended;
    load_expect(int'(sel));
    widx = 0;
    stall_left = stall_sched[0];
    done_cnt = 0;
    done_cyc = -1;
    lock_level = lock;
    end_c = 0;
    next_cycle();
    chk({tag, "_idle_before"}, 64'(busy), 64'd0);
    start = 1'b1;
    freq_sel = sel;
    acc = cyc;
    glitch_cyc = (glitch_rel >= 0) ? acc + glitch_rel : -100;
    next_cycle();
    start = 1'b0;
    freq_sel = ~sel;
    chk({tag, "_busy_at_start"}, 64'(busy), 64'd1);
    chk({tag, "_error_cleared"}, 64'(error), 64'd0);
    ended = 0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      if (poke_rel > 0 && cyc == acc + poke_rel) begin
        start = 1'b1;
        freq_sel = sel + 2'd1;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        ended = 1;
        end_c = cyc;
      end else begin
        next_cycle();
      end
    end
    start = 1'b0;
    chk({tag, "_finished_in_bound"}, 64'(ended), 64'd1);
    if (ended) begin
      chk({tag, "_writes_done"}, 64'(widx), 64'd5);
      if (exp_err) begin
        chk({tag, "_err_cycle"}, 64'(end_c - acc), 64'(TMO + 1));
        chk({tag, "_error_flag"}, 64'(error), 64'd1);
        chk({tag, "_no_done"}, 64'(done_cnt), 64'd0);
      end else begin
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_latency"}, 64'(done_cyc - acc), 64'(exp_lat));
        chk({tag, "_busy_drop"}, 64'(end_c - done_cyc), 64'd1);
        chk({tag, "_error_flag"}, 64'(error), 64'd0);
      end
      chk({tag, "_cur_sel"}, 64'(cur_sel), 64'(exp_cur));
      chk({tag, "_read_low"}, 64'(mgmt.mgmt_read), 64'd0);
    end
    glitch_cyc = -100;
    lock_level = 1'b1;
    repeat (3) next_cycle();
    chk({tag, "_no_requeue"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int   acc;
    vecs[0] = '{sel: 2'd2, stall_m: 0,  glitch_rel: -1,  lock: 1'b1, exp_lat: 326, exp_err: 1'b0, exp_cur: 2'd2};
    vecs[1] = '{sel: 2'd1, stall_m: 10, glitch_rel: -1,  lock: 1'b1, exp_lat: 336, exp_err: 1'b0, exp_cur: 2'd1};
    vecs[2] = '{sel: 2'd3, stall_m: 0,  glitch_rel: 319, lock: 1'b1, exp_lat: 578, exp_err: 1'b0, exp_cur: 2'd3};
    vecs[3] = '{sel: 2'd0, stall_m: 0,  glitch_rel: -1,  lock: 1'b0, exp_lat: 0,   exp_err: 1'b1, exp_cur: 2'd3};
    vecs[4] = '{sel: 2'd3, stall_m: 0,  glitch_rel: -1,  lock: 1'b1, exp_lat: 326, exp_err: 1'b0, exp_cur: 2'd3};

    rst = 1'b1;
    repeat (3) next_cycle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_cur_sel", 64'(cur_sel), 64'd0);
    chk("rst_write", 64'(mgmt.mgmt_write), 64'd0);
    chk("rst_addr", 64'(mgmt.mgmt_address), 64'd0);
    chk("rst_data", 64'(mgmt.mgmt_writedata), 64'd0);
    rst = 1'b0;
    repeat (4) next_cycle();

    for (int v = 0; v < 5; v++) begin
      stall_sched = '{0, 0, vecs[v].stall_m, 0, 0, 0};
      run_seq($sformatf("vec%0d", v), vecs[v].sel, vecs[v].glitch_rel, vecs[v].lock, 0,
              vecs[v].exp_lat, vecs[v].exp_err, vecs[v].exp_cur);
    end

    // start during WR_C0 must not disturb the captured profile
    stall_sched = '{0, 0, 0, 0, 0, 0};
    run_seq("poke_c0", 2'd1, -1, 1'b1, 4, 326, 1'b0, 2'd1);

    for (int r = 0; r < 6; r++) begin
      int sum;
      int g;
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      sum = 0;
      for (int k = 0; k < 5; k++) begin
        stall_sched[k] = $urandom_range(0, 3);
        sum += stall_sched[k];
      end
      stall_sched[5] = 0;
      g = -1;
      if ($urandom_range(0, 1) == 1) g = $urandom_range(5 + sum + SET - 8, 5 + sum + SET + LCK - 6);
      run_seq($sformatf("rand%0d", r), s, g, 1'b1, 0, model_latency(sum, g), 1'b0, s);
    end

    // reset while the M write is stalled aborts everything
    stall_sched = '{0, 0, 5, 0, 0, 0};
    load_expect(0);
    widx = 0;
    stall_left = 0;
    next_cycle();
    start = 1'b1;
    freq_sel = 2'd0;
    acc = cyc;
    next_cycle();
    start = 1'b0;
    while (cyc < acc + 4) next_cycle();
    chk("pre_rst_write", 64'(mgmt.mgmt_write), 64'd1);
    chk("pre_rst_addr", 64'(mgmt.mgmt_address), 64'h04);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk("abort_write", 64'(mgmt.mgmt_write), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_addr", 64'(mgmt.mgmt_address), 64'd0);
    chk("abort_data", 64'(mgmt.mgmt_writedata), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_error", 64'(error), 64'd0);
    chk("abort_cur_sel", 64'(cur_sel), 64'd0);
    repeat (2) next_cycle();
    stall_sched = '{0, 0, 0, 0, 0, 0};
    run_seq("after_rst", 2'd2, -1, 1'b1, 0, 326, 1'b0, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer that retunes the fractional reconfigurable PLL output clock at run time. It selects one of four stored frequency profiles.
- Acts as an Avalon-MM master to the PLL reconfiguration core. That core drives reconfig_to_pll of the PLL wrapper.
- Sequence per request: write mode, N, M and C0 counter registers, trigger the reconfiguration, then wait for the PLL to re-lock.
- Reports busy/done/error to the system controller.

Parameters:
- TIMEOUT_CYCLES, 1000000, maximum refclk cycles from start acceptance to done before error (20 ms at 50 MHz).
- SETTLE_CYCLES, 64, cycles ignored after the start-register write completes, before lock is evaluated.
- LOCK_STABLE, 256, consecutive cycles locked_sync must be high to declare lock.

Ports:
- refclk, input, 1, 50 MHz reference and management clock (sole clock).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request reconfiguration; sampled only in IDLE.
- freq_sel, input, 2, profile index, captured on accepted start.
- pll_locked, input, 1, PLL locked (asynchronous); 2-flop synchronised internally to locked_sync.
- mgmt_address, output, 6, reconfig-core register address.
- mgmt_write, output, 1, write strobe.
- mgmt_writedata, output, 32, write data.
- mgmt_read, output, 1, constant 0.
- mgmt_waitrequest, input, 1, core stall.
- busy, output, 1, high from accepted start until DONE/ERR exit.
- done, output, 1, one-cycle pulse on successful relock.
- error, output, 1, sticky timeout flag; cleared on next accepted start.
- cur_sel, output, 2, profile currently applied.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-sequence aborts immediately: mgmt_write drops the same cycle the reset is sampled. No partial recovery; the PLL keeps whatever was written.
- Profiles (50 MHz ref, N bypassed, M hi=4 lo=4 → VCO 400 MHz):
  - 0: C0 2/2 → 100 MHz
  - 1: C0 4/4 → 50 MHz
  - 2: C0 8/8 → 25 MHz
  - 3: C0 1/1 → 200 MHz
- Counter word format:
  - [7:0] lo count, [15:8] hi count, [16] bypass, [17] odd-duty.
  - C word adds [22:18] counter select = 0.
  - All other bits 0.
- Register writes, in order:
  - MODE addr 0x00 data 0 (waitrequest mode).
  - N addr 0x03 data 0x0001_0000.
  - M addr 0x04 data 0x0000_0404.
  - C0 addr 0x05, data from the selected profile.
  - START addr 0x02 data 0x0000_0001.
- Avalon handshake: address/write/writedata are held stable while mgmt_waitrequest=1. A write completes in the first cycle with mgmt_write=1 and waitrequest=0. The next write is issued the following cycle (no idle cycle required). mgmt_write=0 outside write states.
- States:
  - IDLE → WR_MODE on start. Captures freq_sel, clears error, sets busy, zeroes the timeout counter.
  - WR_MODE → WR_N → WR_M → WR_C0 → WR_START, each advancing on write completion.
  - WR_START → SETTLE: count SETTLE_CYCLES.
  - SETTLE → LOCKWAIT: stable counter increments while locked_sync=1 and resets to 0 when locked_sync=0. At LOCK_STABLE → DONE.
  - DONE: done=1 for one cycle, cur_sel updated, busy=0 next cycle → IDLE.
  - ERR: entered from any non-IDLE state when the timeout counter reaches TIMEOUT_CYCLES-1. error=1 and busy=0 from the next cycle; mgmt_write drops, abandoning any pending write. cur_sel is unchanged → IDLE.
- Timeout counter runs in every non-IDLE state, including while waitrequest stalls a write.
- start while busy: ignored, not queued. start in the same cycle as DONE/ERR exit: ignored; start is accepted only when in IDLE.
- start with freq_sel equal to cur_sel performs the full sequence anyway.
- Latency with no waitrequest and immediate lock: start accepted at cycle 0; writes at cycles 1–5; done at cycle 5+SETTLE_CYCLES+LOCK_STABLE+1.

Test Plan:
1. Reset, then start with freq_sel=2, waitrequest=0, pll_locked=1 → exact write sequence 0x00/0, 0x03/0x10000, 0x04/0x404, 0x05/0x808, 0x02/1; done pulse at cycle 326 (defaults); cur_sel=2; busy low after.
2. waitrequest held high 10 cycles on the M write → address/data stable throughout; exactly one M write completes; sequence continues.
3. pll_locked glitches low for 1 cycle at LOCK_STABLE-5 → stable count restarts; done delayed by the full LOCK_STABLE window from the glitch.
4. pll_locked held 0 with TIMEOUT_CYCLES=2000 → error=1, busy=0, no done, cur_sel unchanged. A subsequent start clears error.
5. start pulsed during WR_C0 with a different freq_sel → ignored; C0 data reflects the originally captured profile.
6. rst asserted while mgmt_write=1 in WR_M → next cycle all outputs 0, state IDLE; a new start runs the complete sequence from MODE.
